// File: rtl/seq_stream_ctrl.sv
// seq_stream_ctrl: serialises a frame of W-bit bytes MSB-first into an
// external clock-enabled sequence detector and counts its detections.
// A one-byte holding buffer lets consecutive bytes stream with no gap;
// when the source stalls, ser_en drops so the detector freezes and the
// bit stream it sees stays contiguous.
// Optional build macro: SEQ_STREAM_HIT_SAT_EN -- when defined, hit_cnt
// saturates at 255; when undefined, hit_cnt wraps 255 -> 0.
module seq_stream_ctrl #(
  parameter int W    = 8,
  parameter int NB_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [NB_W-1:0] nbytes,
  input  logic [W-1:0]    din,
  input  logic            din_valid,
  output logic            din_ready,
  output logic            ser_out,
  output logic            ser_en,
  output logic            det_rst_n,
  input  logic            dec,
  output logic            busy,
  output logic            done,
  output logic [7:0]      hit_cnt
);

  localparam int BIT_W = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_SHIFT,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [W-1:0]      shift_q;
  logic [W-1:0]      buf_q;
  logic              buf_full_q;
  // Bytes of the frame that have not yet entered the shift register
  // (a byte sitting in the holding buffer still counts as remaining).
  logic [NB_W-1:0]   rem_q;
  logic [BIT_W-1:0]  bit_q;
  logic              ser_en_q;
  logic              ser_en_prev_q;
  logic              busy_q;
  logic              done_q;
  logic              det_rst_n_q;
  logic [7:0]        hit_q;
  logic [7:0]        hit_d;

  logic din_fire;
  logic last_bit;

  // Accept a byte in LOAD, or in SHIFT while the holding buffer is free
  // and the frame still needs more bytes than are already in hand.
  assign din_ready = (state_q == S_LOAD) ||
                     ((state_q == S_SHIFT) && !buf_full_q && (rem_q != '0));
  assign din_fire  = din_valid && din_ready;
  assign last_bit  = (bit_q == BIT_W'(W - 1));

  assign ser_en    = ser_en_q;
  assign ser_out   = ser_en_q & shift_q[W-1];
  assign det_rst_n = det_rst_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign hit_cnt   = hit_q;

  // Frame sequencer: state, datapath and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      buf_q         <= '0;
      buf_full_q    <= 1'b0;
      rem_q         <= '0;
      bit_q         <= '0;
      ser_en_q      <= 1'b0;
      ser_en_prev_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      det_rst_n_q   <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      det_rst_n_q   <= 1'b1;
      ser_en_prev_q <= ser_en_q;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_CLR;
            rem_q       <= nbytes;
            buf_full_q  <= 1'b0;
            busy_q      <= 1'b1;
            det_rst_n_q <= 1'b0;
          end
        end
        S_CLR: begin
          state_q <= (rem_q == '0) ? S_FLUSH : S_LOAD;
        end
        S_LOAD: begin
          if (din_fire) begin
            shift_q  <= din;
            rem_q    <= rem_q - NB_W'(1);
            bit_q    <= '0;
            ser_en_q <= 1'b1;
            state_q  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!last_bit) begin
            shift_q <= shift_q << 1;
            bit_q   <= bit_q + BIT_W'(1);
            if (din_fire) begin
              buf_q      <= din;
              buf_full_q <= 1'b1;
            end
          end else begin
            bit_q <= '0;
            if (rem_q == '0) begin
              ser_en_q <= 1'b0;
              state_q  <= S_FLUSH;
            end else if (buf_full_q) begin
              shift_q    <= buf_q;
              buf_full_q <= 1'b0;
              rem_q      <= rem_q - NB_W'(1);
            end else if (din_fire) begin
              // Byte arriving on the final bit goes straight into the shifter.
              shift_q <= din;
              rem_q   <= rem_q - NB_W'(1);
            end else begin
              ser_en_q <= 1'b0;
              state_q  <= S_LOAD;
            end
          end
        end
        S_FLUSH: begin
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          ser_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Next detection count: cleared in CLR, bumped when dec follows an enabled bit.
  always_comb begin
    hit_d = hit_q;
    if (state_q == S_CLR) begin
      hit_d = '0;
    end else if (dec && ser_en_prev_q) begin
`ifdef SEQ_STREAM_HIT_SAT_EN
      if (hit_q != 8'hFF) begin
        hit_d = hit_q + 8'd1;
      end
`else
      hit_d = hit_q + 8'd1;
`endif
    end
  end

  // Detection counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= '0;
    end else begin
      hit_q <= hit_d;
    end
  end

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Bench for seq_stream_ctrl: a 1110011 detector model closes the loop,
// frames are driven from directed byte lists, and a monitor compares each
// finished frame (on done) against the expectation queued at frame start.
module tb_seq_stream_ctrl;

  localparam int W    = 8;
  localparam int NB_W = 8;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [NB_W-1:0] nbytes;
  logic [W-1:0]    din;
  logic            din_valid;
  logic            din_ready;
  logic            ser_out;
  logic            ser_en;
  logic            det_rst_n;
  logic            dec;
  logic            busy;
  logic            done;
  logic [7:0]      hit_cnt;

  seq_stream_ctrl #(.W(W), .NB_W(NB_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .nbytes    (nbytes),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .ser_out   (ser_out),
    .ser_en    (ser_en),
    .det_rst_n (det_rst_n),
    .dec       (dec),
    .busy      (busy),
    .done      (done),
    .hit_cnt   (hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Detector model: overlapping 1110011 match, registered output, enabled by ser_en.
  logic [6:0] hist;
  always @(posedge clk) begin
    if (!det_rst_n) begin
      hist <= '0;
      dec  <= 1'b0;
    end else if (ser_en) begin
      hist <= {hist[5:0], ser_out};
      dec  <= ({hist[5:0], ser_out} == 7'b1110011);
    end
  end

  typedef struct {
    string name;
    int    hits;
    int    sers;
    int    span;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] byte_arr [0:199];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: tracks ser_en activity per frame and checks results on done.
  int cyc = 0;
  int ser_cnt = 0;
  int first_cyc = -1;
  int last_cyc = -1;
  int span;
  bit done_pending = 0;
  always @(negedge clk) begin
    cyc++;
    if (done_pending) begin
      chk("done_width", {31'd0, done}, 32'd0);
      done_pending = 0;
    end
    if (!det_rst_n) begin
      ser_cnt   = 0;
      first_cyc = -1;
      last_cyc  = -1;
    end else if (ser_en) begin
      ser_cnt++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
    end
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard, required none");
      end else begin
        cur  = sb.pop_front();
        span = (first_cyc < 0) ? 0 : (last_cyc - first_cyc + 1);
        chk({cur.name, "_hits"}, {24'd0, hit_cnt}, cur.hits);
        chk({cur.name, "_ser_en_cycles"}, ser_cnt, cur.sers);
        chk({cur.name, "_ser_span"}, span, cur.span);
        $display("frame %s: hit_cnt=%0d ser_en=%0d span=%0d (exp %0d/%0d/%0d)",
                 cur.name, hit_cnt, ser_cnt, span, cur.hits, cur.sers, cur.span);
        done_pending = 1;
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    din       = b;
    din_valid = 1'b1;
    while (!din_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!din_ready) begin
      checks++;
      errors++;
      $display("FAIL din_ready_timeout: got din_ready=0 after %0d cycles, required 1", n);
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy=1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic start_frame(input int n);
    @(negedge clk);
    start  = 1'b1;
    nbytes = NB_W'(n);
    @(negedge clk);
    start  = 1'b0;
    nbytes = '0;
  endtask

  // One frame: queue expectation, start, feed bytes (optional stall before byte 1).
  task automatic run_frame(input string nm, input int n, input int gap,
                           input int hits, input bit poke_start);
    exp_t e;
    int   w;
    e.name = nm;
    e.hits = hits;
    e.sers = 8 * n;
    e.span = (n == 0) ? 0 : (8 * n + gap);
    sb.push_back(e);
    start_frame(n);
    for (int k = 0; k < n; k++) begin
      if (k == 1 && gap > 0) begin
        w = 0;
        while (!(din_ready && !ser_en) && w < 100) begin
          @(negedge clk);
          w++;
        end
        repeat (gap - 1) @(negedge clk);
      end
      push_byte(byte_arr[k]);
      if (k == 0 && poke_start) begin
        start  = 1'b1;
        nbytes = 8'd5;
        @(negedge clk);
        @(negedge clk);
        start  = 1'b0;
        nbytes = '0;
      end
    end
    wait_idle();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int w;
  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    nbytes    = '0;
    din       = '0;
    din_valid = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_din_ready", {31'd0, din_ready}, 0);
    chk("rst_ser_en", {31'd0, ser_en}, 0);
    chk("rst_det_rst_n", {31'd0, det_rst_n}, 0);
    chk("rst_hit_cnt", {24'd0, hit_cnt}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("det_rst_n_release", {31'd0, det_rst_n}, 1);

    // Single byte 0xE6 with a start poke during SHIFT that must be ignored.
    byte_arr[0] = 8'hE6;
    run_frame("single_E6", 1, 0, 1, 1'b1);

    // Two bytes back to back: 1110011001110011 holds two matches.
    byte_arr[0] = 8'hE6;
    byte_arr[1] = 8'h73;
    run_frame("two_nogap", 2, 0, 2, 1'b0);
    run_frame("two_gap5", 2, 5, 2, 1'b0);

    // Match straddling the byte boundary across a stall.
    byte_arr[0] = 8'h0E;
    byte_arr[1] = 8'h60;
    run_frame("straddle_gap3", 2, 3, 1, 1'b0);

    // Empty frame.
    run_frame("zero_len", 0, 0, 0, 1'b0);

    // Asynchronous reset mid-SHIFT after some hits have accumulated.
    byte_arr[0] = 8'hE7;
    byte_arr[1] = 8'h39;
    start_frame(3);
    push_byte(byte_arr[0]);
    push_byte(byte_arr[1]);
    w = 0;
    while (!(hit_cnt != 0 && ser_en) && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("pre_reset_hits_nonzero", {31'd0, (hit_cnt != 0)}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_ser_en", {31'd0, ser_en}, 0);
    chk("midrst_ser_out", {31'd0, ser_out}, 0);
    chk("midrst_din_ready", {31'd0, din_ready}, 0);
    chk("midrst_det_rst_n", {31'd0, det_rst_n}, 0);
    chk("midrst_hit_cnt", {24'd0, hit_cnt}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    byte_arr[0] = 8'hE6;
    run_frame("after_reset_E6", 1, 0, 1, 1'b0);

    // 188 bytes of repeating 11100 -> 300 detections in one frame.
    for (int k = 0; k < 188; k++) begin
      case (k % 5)
        0: byte_arr[k] = 8'hE7;
        1: byte_arr[k] = 8'h39;
        2: byte_arr[k] = 8'hCE;
        3: byte_arr[k] = 8'h73;
        default: byte_arr[k] = 8'h9C;
      endcase
    end
`ifdef SEQ_STREAM_HIT_SAT_EN
    run_frame("hits_300", 188, 0, 255, 1'b0);
    repeat (3) @(negedge clk);
    chk("hit_hold_after_done", {24'd0, hit_cnt}, 255);
`else
    run_frame("hits_300", 188, 0, 44, 1'b0);
    repeat (3) @(negedge clk);
    chk("hit_hold_after_done", {24'd0, hit_cnt}, 44);
`endif
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
